// File: rtl/rotary_encoder_ctrl.sv
// Rotary encoder front end: input sync, debounce, quadrature decode, bounded position counter.
// Long-press detection is built only when ROTARY_LONG_PRESS_EN is defined.
module rotary_encoder_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8,
    parameter int CNT_MAX     = 255,
    parameter int WRAP        = 1,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ROTA,
    input  logic             ROTB,
    input  logic             ROTC,
    input  logic             CLR,
    output logic             UP,
    output logic             DOWN,
    output logic             ENTER,
    output logic             LONG,
    output logic [CNT_W-1:0] POS,
    output logic             AT_MIN,
    output logic             AT_MAX
);
    localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] POS_MAX  = CNT_W'(CNT_MAX);
    // Channel order is {C, B, A}; A and B idle high, the button idles released.
    localparam logic [2:0]       IDLE_LVL = 3'b011;

    logic [2:0]       raw;
    logic [2:0]       s1_q;
    logic [2:0]       s2_q;
    logic [2:0]       filt_q;
    logic [2:0]       filt_d;
    logic [2:0]       prev_q;
    logic [DEB_W-1:0] cnt_q [3];
    logic [DEB_W-1:0] cnt_d [3];

    assign raw = {ROTC, ROTB, ROTA};

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q   <= IDLE_LVL;
            s2_q   <= IDLE_LVL;
            filt_q <= IDLE_LVL;
            prev_q <= IDLE_LVL;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            prev_q <= filt_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A step is a rising filtered A; B's level at that moment gives direction.
    logic step_up;
    logic step_dn;
    logic press;

    assign step_up = filt_q[0] & ~prev_q[0] & ~filt_q[1];
    assign step_dn = filt_q[0] & ~prev_q[0] &  filt_q[1];
    assign press   = filt_q[2] & ~prev_q[2];

    logic [CNT_W-1:0] pos_q;
    logic [CNT_W-1:0] pos_d;
    logic             up_q;
    logic             dn_q;
    logic             enter_q;
    logic             at_min_q;
    logic             at_max_q;

    always_comb begin
        pos_d = pos_q;
        if (CLR) begin
            pos_d = '0;
        end else if (step_up) begin
            if (pos_q >= POS_MAX) begin
                pos_d = (WRAP != 0) ? '0 : POS_MAX;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end else if (step_dn) begin
            if (pos_q == '0) begin
                pos_d = (WRAP != 0) ? POS_MAX : '0;
            end else begin
                pos_d = pos_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos_q    <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            enter_q  <= 1'b0;
            at_min_q <= 1'b1;
            at_max_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            up_q     <= step_up;
            dn_q     <= step_dn;
            enter_q  <= press;
            at_min_q <= (pos_d == '0);
            at_max_q <= (pos_d == POS_MAX);
        end
    end

    assign UP     = up_q;
    assign DOWN   = dn_q;
    assign ENTER  = enter_q;
    assign POS    = pos_q;
    assign AT_MIN = at_min_q;
    assign AT_MAX = at_max_q;

`ifdef ROTARY_LONG_PRESS_EN
    localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] press_cnt_q;
    logic              long_done_q;
    logic              long_q;

    // The counter sits at 0 while released, so every press starts timing from 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            press_cnt_q <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!filt_q[2]) begin
                press_cnt_q <= '0;
                long_done_q <= 1'b0;
            end else if (!long_done_q) begin
                if (press_cnt_q == LONG_LAST) begin
                    long_q      <= 1'b1;
                    long_done_q <= 1'b1;
                end else begin
                    press_cnt_q <= press_cnt_q + 1'b1;
                end
            end
        end
    end

    assign LONG = long_q;
`else
    assign LONG = 1'b0;
`endif

endmodule
